// File: rtl/bus_ram_responder_if.sv
// ============================================================================
// bus_ram_responder_if : multiplexed address/data bus between initiator and responder. Rev 1.0
// ============================================================================
`default_nettype none

interface bus_ram_responder_if;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  busrt_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic [31:0] address_dataOUT;
  logic        data_validOUT;
  logic        end_transactionOUT;
  logic        busyOUT;
  logic        errorOUT;

  modport slave (
    input  address_dataIN, byte_enableIN, busrt_sizeIN, read_n_writeIN,
    input  begin_transactionIN, end_transactionIN, data_validIN, busyIN,
    output address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
  );

  modport master (
    output address_dataIN, byte_enableIN, busrt_sizeIN, read_n_writeIN,
    output begin_transactionIN, end_transactionIN, data_validIN, busyIN,
    input  address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
  );
endinterface

`default_nettype wire

// File: rtl/bus_ram_responder.sv
// ============================================================================
// bus_ram_responder : burst bus slave over an internal word RAM; range check via BUS_RAM_RESPONDER_ERROR_EN. Rev 1.0
// ============================================================================
`default_nettype none

module bus_ram_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned ADDR_BITS    = 9
) (
  input  wire logic          clock,
  input  wire logic          reset,
  bus_ram_responder_if.slave bus
);
  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam int unsigned TAG_LSB = ADDR_BITS + 2;
  localparam logic [ADDR_BITS-1:0] IDX_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, WRITE, READ_FETCH, READ, END
`ifdef BUS_RAM_RESPONDER_ERROR_EN
    , ERROR
`endif
  } state_t;

  state_t               state;
  logic [31:0]          ram [DEPTH];
  logic [ADDR_BITS-1:0] index;
  logic [8:0]           count;
  logic [3:0]           lanes;
  logic [31:0]          rdata;
  logic                 rvalid;
  logic                 rend;

  logic                 selected;
  logic [ADDR_BITS-1:0] begin_index;
  logic                 ram_we;
  logic                 unused_addr_lsbs;

  assign selected    = bus.begin_transactionIN &&
                       (bus.address_dataIN[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
  assign begin_index = bus.address_dataIN[TAG_LSB-1:2];
  assign unused_addr_lsbs = ^bus.address_dataIN[1:0];

  // Reset wins over a coincident beat so nothing lands in RAM once reset is seen.
  assign ram_we = !reset && (state == WRITE) && bus.data_validIN && (count != 9'd0);

  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) ram[index][8*b +: 8] <= bus.address_dataIN[8*b +: 8];
      end
    end
  end

`ifdef BUS_RAM_RESPONDER_ERROR_EN
  logic                 rerr;
  logic [ADDR_BITS+8:0] reach;
  logic                 range_fault;

  assign reach       = (ADDR_BITS+9)'(begin_index) + (ADDR_BITS+9)'(bus.busrt_sizeIN);
  assign range_fault = reach > (ADDR_BITS+9)'(DEPTH - 1);
  assign bus.errorOUT = rerr;
`else
  assign bus.errorOUT = 1'b0;
`endif

  assign bus.address_dataOUT    = rdata;
  assign bus.data_validOUT      = rvalid;
  assign bus.end_transactionOUT = rend;
  assign bus.busyOUT            = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      index  <= '0;
      count  <= '0;
      lanes  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      rend   <= 1'b0;
`ifdef BUS_RAM_RESPONDER_ERROR_EN
      rerr   <= 1'b0;
`endif
    end else begin
      rend <= 1'b0;
`ifdef BUS_RAM_RESPONDER_ERROR_EN
      rerr <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (selected) begin
            index <= begin_index;
            lanes <= bus.byte_enableIN;
`ifdef BUS_RAM_RESPONDER_ERROR_EN
            if (range_fault) begin
              state <= ERROR;
              rerr  <= 1'b1;
              rend  <= 1'b1;
            end else
`endif
            if (bus.read_n_writeIN) begin
              state <= READ_FETCH;
              count <= {1'b0, bus.busrt_sizeIN};
            end else begin
              // Write counter holds beats remaining, so zero means exhausted.
              state <= WRITE;
              count <= {1'b0, bus.busrt_sizeIN} + 9'd1;
            end
          end
        end
        WRITE: begin
          if (ram_we) begin
            index <= index + IDX_ONE;
            count <= count - 9'd1;
          end
          if (bus.end_transactionIN) state <= IDLE;
        end
        READ_FETCH: begin
          if (bus.end_transactionIN) begin
            state <= IDLE;
          end else begin
            rdata  <= ram[index];
            rvalid <= 1'b1;
            index  <= index + IDX_ONE;
            state  <= READ;
          end
        end
        READ: begin
          if (bus.end_transactionIN) begin
            state  <= IDLE;
            rvalid <= 1'b0;
            rdata  <= '0;
          end else if (!bus.busyIN) begin
            // Read counter holds beats remaining after the one on the bus.
            if (count == 9'd0) begin
              state  <= END;
              rvalid <= 1'b0;
              rdata  <= '0;
              rend   <= 1'b1;
            end else begin
              rdata <= ram[index];
              index <= index + IDX_ONE;
              count <= count - 9'd1;
            end
          end
        end
        END: begin
          state <= IDLE;
        end
`ifdef BUS_RAM_RESPONDER_ERROR_EN
        ERROR: begin
          state <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_bus_ram_responder.sv
// ============================================================================
// tb_bus_ram_responder : randomized self-checking bench against a word-array model. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bus_ram_responder;
  localparam logic [31:0] BASE  = 32'h5000_0000;
  localparam int          AB    = 9;
  localparam int          DEPTH = 512;

  logic clock = 1'b0;
  logic reset;

  bus_ram_responder_if bus();

  bus_ram_responder #(.BASE_ADDRESS(BASE), .ADDR_BITS(AB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  logic [31:0] mem   [DEPTH];
  logic [3:0]  known [DEPTH];
  logic [31:0] wr_data [$];
  logic [31:0] rd_data [$];
  int          rd_cyc  [$];
  bit          rd_acc  [$];
  int          rd_end;
  int          rd_err;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    bus.address_dataIN      = '0;
    bus.byte_enableIN       = '0;
    bus.busrt_sizeIN        = '0;
    bus.read_n_writeIN      = 1'b0;
    bus.begin_transactionIN = 1'b0;
    bus.end_transactionIN   = 1'b0;
    bus.data_validIN        = 1'b0;
    bus.busyIN              = 1'b0;
  endtask

  function automatic logic [31:0] lane_mask(logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  function automatic int word_of(logic [31:0] addr);
    return int'((addr - BASE) >> 2) % DEPTH;
  endfunction

  // Model: every beat lands at successive word indices (wrapping), masked by lanes.
  task automatic do_write(logic [31:0] addr, logic [3:0] be, int n);
    bus.address_dataIN      = addr;
    bus.byte_enableIN       = be;
    bus.busrt_sizeIN        = 8'(n - 1);
    bus.read_n_writeIN      = 1'b0;
    bus.begin_transactionIN = 1'b1;
    step();
    bus.begin_transactionIN = 1'b0;
    for (int i = 0; i < n; i++) begin
      int w;
      bus.address_dataIN    = wr_data[i];
      bus.data_validIN      = 1'b1;
      bus.end_transactionIN = (i == n - 1);
      step();
      w = (word_of(addr) + i) % DEPTH;
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[w][8*b +: 8] = wr_data[i][8*b +: 8];
          known[w][b] = 1'b1;
        end
      end
    end
    idle_bus();
  endtask

  // Collects every valid cycle (data, cycle number, accepted) until the end strobe.
  task automatic do_read(logic [31:0] addr, int n, logic [31:0] pat);
    rd_data.delete();
    rd_cyc.delete();
    rd_acc.delete();
    rd_end = -1;
    rd_err = -1;
    bus.address_dataIN      = addr;
    bus.busrt_sizeIN        = 8'(n - 1);
    bus.read_n_writeIN      = 1'b1;
    bus.begin_transactionIN = 1'b1;
    step();
    idle_bus();
    for (int c = 1; c < 600; c++) begin
      bus.busyIN = (c < 32) ? pat[c] : 1'b0;
      if (bus.errorOUT) rd_err = c;
      if (bus.data_validOUT) begin
        rd_data.push_back(bus.address_dataOUT);
        rd_cyc.push_back(c);
        rd_acc.push_back(!bus.busyIN);
      end
      if (bus.end_transactionOUT) begin
        rd_end = c;
        step();
        break;
      end
      step();
    end
    idle_bus();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_bus();
    step();
    step();
    checks++;
    if ({bus.address_dataOUT, bus.data_validOUT, bus.end_transactionOUT, bus.busyOUT, bus.errorOUT} !== 36'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h %b%b%b%b required all zero", bus.address_dataOUT,
               bus.data_validOUT, bus.end_transactionOUT, bus.busyOUT, bus.errorOUT);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_burst_write_read();
    logic [31:0] exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    wr_data = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_write(BASE + 32'h10, 4'hF, 4);
    do_read(BASE + 32'h10, 4, 32'h0);
    checks++;
    if (rd_data.size() != 4) begin
      fails++;
      $display("FAIL burst_beat_count: got %0d required 4", rd_data.size());
    end
    for (int i = 0; i < rd_data.size() && i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp[i] || rd_cyc[i] != i + 2) begin
        fails++;
        $display("FAIL burst_beat%0d: got %h at cycle %0d required %h at cycle %0d",
                 i, rd_data[i], rd_cyc[i], exp[i], i + 2);
      end
    end
    checks++;
    if (rd_end != 6) begin
      fails++;
      $display("FAIL burst_end_cycle: got %0d required 6", rd_end);
    end
  endtask

  task automatic test_byte_enable();
    wr_data = '{32'h0000_0000};
    do_write(BASE, 4'hF, 1);
    wr_data = '{32'hAABB_CCDD};
    do_write(BASE, 4'b0101, 1);
    do_read(BASE, 1, 32'h0);
    checks++;
    if (rd_data.size() != 1 || rd_data[0] !== 32'h00BB_00DD || rd_end != 3) begin
      fails++;
      $display("FAIL byte_enable: got %h (beats %0d, end %0d) required 00bb00dd (beats 1, end 3)",
               (rd_data.size() > 0) ? rd_data[0] : 32'hx, rd_data.size(), rd_end);
    end
  endtask

  task automatic test_busy_stall();
    logic [31:0] exp_d [5] = '{32'h11, 32'h22, 32'h22, 32'h22, 32'h33};
    int          exp_c [5] = '{2, 3, 4, 5, 6};
    do_read(BASE + 32'h10, 3, 32'h0000_0018);
    checks++;
    if (rd_data.size() != 5) begin
      fails++;
      $display("FAIL stall_valid_cycles: got %0d required 5", rd_data.size());
    end
    for (int i = 0; i < rd_data.size() && i < 5; i++) begin
      checks++;
      if (rd_data[i] !== exp_d[i] || rd_cyc[i] != exp_c[i]) begin
        fails++;
        $display("FAIL stall_beat%0d: got %h at cycle %0d required %h at cycle %0d",
                 i, rd_data[i], rd_cyc[i], exp_d[i], exp_c[i]);
      end
    end
    checks++;
    if (rd_end != 7) begin
      fails++;
      $display("FAIL stall_end_cycle: got %0d required 7", rd_end);
    end
  endtask

  task automatic test_unselected();
    bus.address_dataIN      = BASE + 32'h800;
    bus.byte_enableIN       = 4'hF;
    bus.busrt_sizeIN        = 8'd3;
    bus.begin_transactionIN = 1'b1;
    step();
    bus.begin_transactionIN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        idle_bus();
        bus.address_dataIN      = BASE + 32'h800;
        bus.read_n_writeIN      = 1'b1;
        bus.begin_transactionIN = 1'b1;
      end else if (i < 4) begin
        bus.address_dataIN    = 32'hDEAD_BEEF;
        bus.data_validIN      = 1'b1;
        bus.end_transactionIN = (i == 3);
      end else begin
        idle_bus();
      end
      checks++;
      if ({bus.address_dataOUT, bus.data_validOUT, bus.end_transactionOUT, bus.errorOUT} !== 35'd0) begin
        fails++;
        $display("FAIL unselected_quiet cycle %0d: got %h %b%b%b required all zero", i,
                 bus.address_dataOUT, bus.data_validOUT, bus.end_transactionOUT, bus.errorOUT);
      end
      step();
    end
    idle_bus();
    do_read(BASE, 1, 32'h0);
    checks++;
    if (rd_data.size() != 1 || rd_data[0] !== mem[0]) begin
      fails++;
      $display("FAIL unselected_ram_intact: got %h required %h",
               (rd_data.size() > 0) ? rd_data[0] : 32'hx, mem[0]);
    end
  endtask

  task automatic test_wrap();
    wr_data = '{32'h5115_1151};
    do_write(BASE + 32'h7FC, 4'hF, 1);
    wr_data = '{32'h0000_A000};
    do_write(BASE, 4'hF, 1);
    do_read(BASE + 32'h7FC, 2, 32'h0);
`ifdef BUS_RAM_RESPONDER_ERROR_EN
    checks++;
    if (rd_err != 1 || rd_end != 1 || rd_data.size() != 0) begin
      fails++;
      $display("FAIL range_error: got err@%0d end@%0d beats %0d required err@1 end@1 beats 0",
               rd_err, rd_end, rd_data.size());
    end
`else
    checks++;
    if (rd_data.size() != 2 || rd_data[0] !== mem[DEPTH-1] || rd_data[1] !== mem[0] || rd_end != 4) begin
      fails++;
      $display("FAIL wrap_read: beats %0d end %0d required %h,%h end 4",
               rd_data.size(), rd_end, mem[DEPTH-1], mem[0]);
    end
    checks++;
    if (rd_err != -1) begin
      fails++;
      $display("FAIL wrap_no_error: got error at cycle %0d required none", rd_err);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] nd [4] = '{32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3, 32'hD4D4_D4D4};
    wr_data = '{32'h1000_0020, 32'h1000_0021, 32'h1000_0022, 32'h1000_0023};
    do_write(BASE + 32'h50, 4'hF, 4);
    bus.address_dataIN      = BASE + 32'h50;
    bus.byte_enableIN       = 4'hF;
    bus.busrt_sizeIN        = 8'd3;
    bus.begin_transactionIN = 1'b1;
    step();
    bus.begin_transactionIN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.address_dataIN    = nd[i];
      bus.data_validIN      = 1'b1;
      bus.end_transactionIN = (i == 3);
      reset                 = (i == 1);
      step();
      if (i == 1) begin
        checks++;
        if ({bus.address_dataOUT, bus.data_validOUT, bus.end_transactionOUT, bus.errorOUT} !== 35'd0) begin
          fails++;
          $display("FAIL reset_mid_write_outputs: got %h %b%b%b required all zero",
                   bus.address_dataOUT, bus.data_validOUT, bus.end_transactionOUT, bus.errorOUT);
        end
      end
    end
    reset = 1'b0;
    idle_bus();
    mem[20] = nd[0];
    known[21] = 4'h0;
    do_read(BASE + 32'h50, 4, 32'h0);
    checks++;
    if (rd_data.size() != 4 || rd_end != 6) begin
      fails++;
      $display("FAIL reset_mid_write_readback: beats %0d end %0d required 4 beats end 6", rd_data.size(), rd_end);
    end
    for (int i = 0; i < rd_data.size() && i < 4; i++) begin
      logic [31:0] m;
      m = lane_mask(known[20 + i]);
      checks++;
      if ((rd_data[i] & m) !== (mem[20 + i] & m)) begin
        fails++;
        $display("FAIL reset_mid_write_word%0d: got %h required %h (mask %h)", 20 + i, rd_data[i], mem[20 + i], m);
      end
    end
    // Reset in the middle of a read must drop valid at once.
    bus.address_dataIN      = BASE + 32'h50;
    bus.busrt_sizeIN        = 8'd3;
    bus.read_n_writeIN      = 1'b1;
    bus.begin_transactionIN = 1'b1;
    step();
    idle_bus();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.address_dataOUT, bus.data_validOUT, bus.end_transactionOUT, bus.errorOUT} !== 35'd0) begin
      fails++;
      $display("FAIL reset_mid_read_outputs: got %h %b%b%b required all zero",
               bus.address_dataOUT, bus.data_validOUT, bus.end_transactionOUT, bus.errorOUT);
    end
    do_read(BASE + 32'h58, 1, 32'h0);
    checks++;
    if (rd_data.size() != 1 || rd_data[0] !== mem[22] || rd_end != 3) begin
      fails++;
      $display("FAIL after_reset_read: got %h end %0d required %h end 3",
               (rd_data.size() > 0) ? rd_data[0] : 32'hx, rd_end, mem[22]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int          n;
      int          idx;
      int          k;
      int          c;
      int          acc;
      logic [3:0]  be;
      logic [31:0] pat;
      n   = $urandom_range(1, 16);
      idx = $urandom_range(0, DEPTH - n);
      be  = 4'($urandom_range(1, 15));
      pat = $urandom & $urandom;
      wr_data.delete();
      for (int i = 0; i < n; i++) wr_data.push_back($urandom);
      do_write(BASE + 32'(idx * 4), be, n);
      do_read(BASE + 32'(idx * 4), n, pat);
      // Expected timeline: beat presented from cycle 2, advances only on non-busy cycles.
      c = 2;
      acc = 0;
      while (acc < n) begin
        if (c < 32 && pat[c]) c++;
        else begin
          acc++;
          c++;
        end
      end
      checks++;
      if (rd_end != c || rd_data.size() != c - 2) begin
        fails++;
        $display("FAIL random%0d_timing: end %0d valid cycles %0d required end %0d valid cycles %0d",
                 it, rd_end, rd_data.size(), c, c - 2);
      end
      k = 0;
      for (int i = 0; i < rd_data.size() && k < n; i++) begin
        logic [31:0] m;
        m = lane_mask(known[idx + k]);
        checks++;
        if ((rd_data[i] & m) !== (mem[idx + k] & m)) begin
          fails++;
          $display("FAIL random%0d_beat%0d: got %h required %h (mask %h)", it, k, rd_data[i], mem[idx + k], m);
        end
        if (rd_acc[i]) k++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]   = '0;
      known[i] = 4'h0;
    end
    idle_bus();
    test_reset();
    test_burst_write_read();
    test_byte_enable();
    test_busy_stall();
    test_unselected();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire
